// File: rtl/axi_ar_allocator_qos.sv
// Read-address allocator: QoS-aware round-robin arbitration of N slave-port AR channels onto one
// registered AR output, with a per-port outstanding-burst limit and port index prepended to ARID.
module axi_ar_allocator_qos #(
    parameter int AXI_ADDRESS_W   = 32,
    parameter int AXI_USER_W      = 6,
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN       = 16,
    parameter int AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter int QOS_EN          = 1,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_TARG_PORT*AXI_ID_IN-1:0]     arid_i,
    input  logic [N_TARG_PORT*AXI_ADDRESS_W-1:0] araddr_i,
    input  logic [N_TARG_PORT*8-1:0]             arlen_i,
    input  logic [N_TARG_PORT*3-1:0]             arsize_i,
    input  logic [N_TARG_PORT*2-1:0]             arburst_i,
    input  logic [N_TARG_PORT-1:0]               arlock_i,
    input  logic [N_TARG_PORT*4-1:0]             arcache_i,
    input  logic [N_TARG_PORT*3-1:0]             arprot_i,
    input  logic [N_TARG_PORT*4-1:0]             arregion_i,
    input  logic [N_TARG_PORT*AXI_USER_W-1:0]    aruser_i,
    input  logic [N_TARG_PORT*4-1:0]             arqos_i,
    input  logic [N_TARG_PORT-1:0]               arvalid_i,
    output logic [N_TARG_PORT-1:0]               arready_o,
    output logic [AXI_ID_OUT-1:0]                arid_o,
    output logic [AXI_ADDRESS_W-1:0]             araddr_o,
    output logic [7:0]                           arlen_o,
    output logic [2:0]                           arsize_o,
    output logic [1:0]                           arburst_o,
    output logic                                 arlock_o,
    output logic [3:0]                           arcache_o,
    output logic [2:0]                           arprot_o,
    output logic [3:0]                           arregion_o,
    output logic [AXI_USER_W-1:0]                aruser_o,
    output logic [3:0]                           arqos_o,
    output logic                                 arvalid_o,
    input  logic                                 arready_i,
    input  logic [N_TARG_PORT-1:0]               rdone_i,
    output logic                                 err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [LOG_N_TARG-1:0] LAST_PORT = LOG_N_TARG'(N_TARG_PORT - 1);

    logic [CNT_W-1:0]         cnt_q [N_TARG_PORT];
    logic [CNT_W-1:0]         cnt_d [N_TARG_PORT];
    logic [LOG_N_TARG-1:0]    ptr_q, ptr_d;
    logic                     err_q, err_d;
    logic                     arvalid_q, arvalid_d;
    logic [AXI_ID_OUT-1:0]    arid_q, arid_d;
    logic [AXI_ADDRESS_W-1:0] araddr_q, araddr_d;
    logic [7:0]               arlen_q, arlen_d;
    logic [2:0]               arsize_q, arsize_d;
    logic [1:0]               arburst_q, arburst_d;
    logic                     arlock_q, arlock_d;
    logic [3:0]               arcache_q, arcache_d;
    logic [2:0]               arprot_q, arprot_d;
    logic [3:0]               arregion_q, arregion_d;
    logic [AXI_USER_W-1:0]    aruser_q, aruser_d;
    logic [3:0]               arqos_q, arqos_d;

    logic [N_TARG_PORT-1:0]   elig, cand;
    logic [3:0]               max_qos;
    logic [LOG_N_TARG-1:0]    win_idx;
    logic                     win_vld, load, grant;

    always_comb begin
        max_qos = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            elig[i] = arvalid_i[i] && (cnt_q[i] < MAX_CNT);
            if (elig[i] && (arqos_i[i*4 +: 4] > max_qos)) max_qos = arqos_i[i*4 +: 4];
        end
        for (int i = 0; i < N_TARG_PORT; i++) begin
            cand[i] = elig[i] && ((QOS_EN == 0) || (arqos_i[i*4 +: 4] == max_qos));
        end
    end

    // Scan downward so the candidate closest at-or-after the pointer is the last one written.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        for (int j = N_TARG_PORT - 1; j >= 0; j--) begin
            idx = (int'(ptr_q) + j) % N_TARG_PORT;
            if (cand[idx]) begin
                win_vld = 1'b1;
                win_idx = LOG_N_TARG'(idx);
            end
        end
    end

    assign load  = ~arvalid_q | arready_i;
    assign grant = win_vld & load & ~rst;

    always_comb begin
        arready_o          = '0;
        arready_o[win_idx] = grant;
    end

    always_comb begin
        ptr_d      = ptr_q;
        arvalid_d  = arvalid_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        arlock_d   = arlock_q;
        arcache_d  = arcache_q;
        arprot_d   = arprot_q;
        arregion_d = arregion_q;
        aruser_d   = aruser_q;
        arqos_d    = arqos_q;
        if (load) arvalid_d = win_vld;
        if (grant) begin
            ptr_d      = (win_idx == LAST_PORT) ? '0 : win_idx + 1'b1;
            arid_d     = {win_idx, arid_i[win_idx*AXI_ID_IN +: AXI_ID_IN]};
            araddr_d   = araddr_i[win_idx*AXI_ADDRESS_W +: AXI_ADDRESS_W];
            arlen_d    = arlen_i[win_idx*8 +: 8];
            arsize_d   = arsize_i[win_idx*3 +: 3];
            arburst_d  = arburst_i[win_idx*2 +: 2];
            arlock_d   = arlock_i[win_idx];
            arcache_d  = arcache_i[win_idx*4 +: 4];
            arprot_d   = arprot_i[win_idx*3 +: 3];
            arregion_d = arregion_i[win_idx*4 +: 4];
            aruser_d   = aruser_i[win_idx*AXI_USER_W +: AXI_USER_W];
            arqos_d    = arqos_i[win_idx*4 +: 4];
        end
    end

    // A simultaneous accept and completion cancel; a completion on an empty counter is flagged.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (rdone_i[i] && (cnt_q[i] == '0)) err_d = 1'b1;
            if (arready_o[i] && arvalid_i[i] && !rdone_i[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rdone_i[i] && !(arready_o[i] && arvalid_i[i]) && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TARG_PORT; i++) cnt_q[i] <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            arlock_q   <= 1'b0;
            arcache_q  <= '0;
            arprot_q   <= '0;
            arregion_q <= '0;
            aruser_q   <= '0;
            arqos_q    <= '0;
        end else begin
            for (int i = 0; i < N_TARG_PORT; i++) cnt_q[i] <= cnt_d[i];
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            arvalid_q  <= arvalid_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            arlock_q   <= arlock_d;
            arcache_q  <= arcache_d;
            arprot_q   <= arprot_d;
            arregion_q <= arregion_d;
            aruser_q   <= aruser_d;
            arqos_q    <= arqos_d;
        end
    end

    assign arvalid_o  = arvalid_q;
    assign arid_o     = arid_q;
    assign araddr_o   = araddr_q;
    assign arlen_o    = arlen_q;
    assign arsize_o   = arsize_q;
    assign arburst_o  = arburst_q;
    assign arlock_o   = arlock_q;
    assign arcache_o  = arcache_q;
    assign arprot_o   = arprot_q;
    assign arregion_o = arregion_q;
    assign aruser_o   = aruser_q;
    assign arqos_o    = arqos_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_axi_ar_allocator_qos.sv
// Bench for axi_ar_allocator_qos: hand sequences for reset/stall/limit corners, then a vector table
// of arbitration patterns; every grant pushes its expected output beat onto a scoreboard queue.
module tb_axi_ar_allocator_qos;
    localparam int N    = 7;
    localparam int AW   = 32;
    localparam int UW   = 6;
    localparam int IDW  = 16;
    localparam int LOG  = 3;
    localparam int IDO  = IDW + LOG;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*IDW-1:0] arid_i;
    logic [N*AW-1:0]  araddr_i;
    logic [N*8-1:0]   arlen_i;
    logic [N*3-1:0]   arsize_i;
    logic [N*2-1:0]   arburst_i;
    logic [N-1:0]     arlock_i;
    logic [N*4-1:0]   arcache_i, arregion_i, arqos_i;
    logic [N*3-1:0]   arprot_i;
    logic [N*UW-1:0]  aruser_i;
    logic [N-1:0]     arvalid_i, arready_o, rdone_i;
    logic [IDO-1:0]   arid_o;
    logic [AW-1:0]    araddr_o;
    logic [7:0]       arlen_o;
    logic [2:0]       arsize_o, arprot_o;
    logic [1:0]       arburst_o;
    logic             arlock_o, arvalid_o, arready_i, err_o;
    logic [3:0]       arcache_o, arregion_o, arqos_o;
    logic [UW-1:0]    aruser_o;

    logic [IDW-1:0] id_v   [N];
    logic [AW-1:0]  addr_v [N];
    logic [7:0]     len_v  [N];
    logic [3:0]     qos_v  [N];
    logic [N-1:0]   valid_v;
    logic [N-1:0]   rdone_man;
    logic [N-1:0]   rdone_auto;
    logic [N-1:0]   pend_mask;
    logic           auto_done;

    typedef struct {
        logic [IDO-1:0] id;
        logic [AW-1:0]  addr;
        logic [34:0]    attr;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [N-1:0] valid;
        logic [27:0]  qos;
        int           exp;
    } vec_t;
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    axi_ar_allocator_qos #(
        .AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N), .LOG_N_TARG(LOG),
        .AXI_ID_IN(IDW), .AXI_ID_OUT(IDO), .QOS_EN(1), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arlock_i(arlock_i), .arcache_i(arcache_i), .arprot_i(arprot_i),
        .arregion_i(arregion_i), .aruser_i(aruser_i), .arqos_i(arqos_i),
        .arvalid_i(arvalid_i), .arready_o(arready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arlock_o(arlock_o), .arcache_o(arcache_o), .arprot_o(arprot_o),
        .arregion_o(arregion_o), .aruser_o(aruser_o), .arqos_o(arqos_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .rdone_i(rdone_i), .err_o(err_o)
    );

    // Attribute fields are derived from port number and length so every beat is distinguishable.
    function automatic logic [34:0] attrIn(int p);
        logic [7:0] l;
        logic [2:0] pp;
        l  = len_v[p];
        pp = 3'(p);
        return {l, pp, 2'b01, pp[0], l[3:0], pp, ~l[3:0], l[5:0], qos_v[p]};
    endfunction

    always_comb begin
        for (int p = 0; p < N; p++) begin
            logic [2:0] pp;
            pp = 3'(p);
            arid_i[p*IDW +: IDW]  = id_v[p];
            araddr_i[p*AW +: AW]  = addr_v[p];
            arlen_i[p*8 +: 8]     = len_v[p];
            arsize_i[p*3 +: 3]    = pp;
            arburst_i[p*2 +: 2]   = 2'b01;
            arlock_i[p]           = pp[0];
            arcache_i[p*4 +: 4]   = len_v[p][3:0];
            arprot_i[p*3 +: 3]    = pp;
            arregion_i[p*4 +: 4]  = ~len_v[p][3:0];
            aruser_i[p*UW +: UW]  = len_v[p][5:0];
            arqos_i[p*4 +: 4]     = qos_v[p];
        end
    end
    assign arvalid_i = valid_v;
    assign rdone_i   = rdone_man | rdone_auto;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output beats are compared whenever the downstream handshake happens.
    always @(negedge clk) begin
        pend_mask = '0;
        if (!rst && arvalid_o && arready_i) begin
            if (auto_done) pend_mask[arid_o[IDO-1 -: LOG]] = 1'b1;
            if (sbq.size() == 0) begin
                checkEq("sb_unexpected_beat", {45'd0, arid_o}, 64'h7FFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkEq("sb_arid", {45'd0, arid_o}, {45'd0, e.id});
                checkEq("sb_araddr", {32'd0, araddr_o}, {32'd0, e.addr});
                checkEq("sb_attr", {29'd0, arlen_o, arsize_o, arburst_o, arlock_o, arcache_o,
                                    arprot_o, arregion_o, aruser_o, arqos_o}, {29'd0, e.attr});
            end
        end
    end

    // Completion for each handshaken beat arrives as a one-cycle pulse one cycle later.
    always @(posedge clk) begin
        #1;
        rdone_auto = pend_mask;
    end

    task automatic checkOutput(input string name, input int exp);
        logic [N-1:0] oh;
        oh = '0;
        if (exp >= 0) oh[exp] = 1'b1;
        checkEq(name, {57'd0, arready_o}, {57'd0, oh});
        if (exp >= 0) begin
            exp_t e;
            e.id   = {3'(exp), id_v[exp]};
            e.addr = addr_v[exp];
            e.attr = attrIn(exp);
            sbq.push_back(e);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [N-1:0] valid, input int exp);
        valid_v = valid;
        @(negedge clk);
        checkOutput(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic setPayload(input int v);
        for (int p = 0; p < N; p++) begin
            id_v[p]   = 16'(v * 256 + p + 1);
            addr_v[p] = 32'hA000_0000 + 32'(v * 256 + p * 4);
            len_v[p]  = 8'(v * 7 + p);
        end
    endtask

    function automatic void addVec(input logic [N-1:0] valid, input logic [27:0] qos, input int exp);
        vec_t t;
        t.valid = valid;
        t.qos   = qos;
        t.exp   = exp;
        tbl.push_back(t);
    endfunction

    initial begin
        for (int p = 0; p < N; p++) begin
            id_v[p] = '0; addr_v[p] = '0; len_v[p] = '0; qos_v[p] = '0;
        end
        valid_v    = '0;
        rdone_man  = '0;
        rdone_auto = '0;
        pend_mask  = '0;
        auto_done  = 1'b1;
        arready_i  = 1'b1;

        // Pointer is 1 when the table starts (last hand-written grant goes to port 0).
        for (int k = 0; k < 3; k++) addVec(7'b0000000, 28'h0, -1);
        addVec(7'b0001011, 28'h0, 1); addVec(7'b0001011, 28'h0, 3); addVec(7'b0001011, 28'h0, 0);
        addVec(7'b0001011, 28'h0, 1); addVec(7'b0001011, 28'h0, 3); addVec(7'b0001011, 28'h0, 0);
        addVec(7'b0110010, 28'h0990020, 4); addVec(7'b0110010, 28'h0990020, 5);
        addVec(7'b0110010, 28'h0990020, 4); addVec(7'b0110010, 28'h0990020, 5);
        addVec(7'b0000010, 28'h0000020, 1);
        addVec(7'b1000001, 28'h0, 6); addVec(7'b1000001, 28'h0, 0); addVec(7'b1000001, 28'h0, 6);
        addVec(7'b0000000, 28'h0, -1);
        addVec(7'b0001100, 28'h0005100, 3); addVec(7'b0001100, 28'h0005100, 3);
        addVec(7'b0001100, 28'h0005100, 2); addVec(7'b0001100, 28'h0005100, 3);
        addVec(7'b0001100, 28'h0005100, 3); addVec(7'b0001100, 28'h0005100, 2);
        for (int k = 0; k < 3; k++) addVec(7'b0000000, 28'h0, -1);

        // Reset state, with a request present that must not be accepted.
        valid_v = 7'b0001000;
        repeat (3) @(posedge clk);
        #1;
        checkEq("rst_arvalid_o", {63'd0, arvalid_o}, 64'd0);
        checkEq("rst_araddr_o", {32'd0, araddr_o}, 64'd0);
        checkEq("rst_arid_o", {45'd0, arid_o}, 64'd0);
        checkEq("rst_err_o", {63'd0, err_o}, 64'd0);
        checkEq("rst_arready_o", {57'd0, arready_o}, 64'd0);
        valid_v = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request on port 2.
        id_v[2] = 16'h0005; addr_v[2] = 32'h0000_1000; len_v[2] = 8'd3;
        applyStimulus("t1_grant", 7'b0000100, 2);
        valid_v = '0;
        @(negedge clk);
        checkEq("t1_arvalid_o", {63'd0, arvalid_o}, 64'd1);
        checkEq("t1_araddr_o", {32'd0, araddr_o}, 64'h1000);
        checkEq("t1_arid_o", {45'd0, arid_o}, {45'd0, 3'd2, 16'h0005});
        @(posedge clk);
        #1;

        // Outstanding limit on port 0, then an underflowing completion on port 6.
        auto_done = 1'b0;
        for (int n = 0; n < 5; n++) begin
            addr_v[0] = 32'h2000 + 32'(n); id_v[0] = 16'(n + 32); len_v[0] = 8'(n);
            rdone_man = (n == 3) ? 7'b0000001 : 7'b0000000;
            applyStimulus($sformatf("t5_req%0d", n), 7'b0000001, (n < 2 || n == 4) ? 0 : -1);
        end
        rdone_man = '0;
        applyStimulus("t5_idle", 7'b0000000, -1);
        rdone_man = 7'b1000000;
        @(posedge clk);
        #1 rdone_man = '0;
        @(negedge clk);
        checkEq("t5_err_set", {63'd0, err_o}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("t5_err_sticky", {63'd0, err_o}, 64'd1);
        @(posedge clk);
        #1;

        // Downstream stall for five cycles, then the next winner loads as ready returns.
        arready_i = 1'b0;
        id_v[1] = 16'h0011; addr_v[1] = 32'h3000; len_v[1] = 8'd9;
        id_v[4] = 16'h0044; addr_v[4] = 32'h4000; len_v[4] = 8'd12;
        applyStimulus("t4_first", 7'b0000010, 1);
        valid_v = 7'b0010000;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkEq($sformatf("t4_stall_ready%0d", n), {57'd0, arready_o}, 64'd0);
            checkEq($sformatf("t4_stall_valid%0d", n), {63'd0, arvalid_o}, 64'd1);
            checkEq($sformatf("t4_stall_addr%0d", n), {32'd0, araddr_o}, 64'h3000);
            checkEq($sformatf("t4_stall_id%0d", n), {45'd0, arid_o}, {45'd0, 3'd1, 16'h0011});
            @(posedge clk);
            #1;
        end
        arready_i = 1'b1;
        applyStimulus("t4_release", 7'b0010000, 4);

        // Asynchronous reset while a beat is held and counters are nonzero.
        arready_i = 1'b0;
        valid_v   = '0;
        @(negedge clk);
        checkEq("t6_held_addr", {32'd0, araddr_o}, 64'h4000);
        #1 rst = 1'b1;
        #1;
        checkEq("t6_rst_arvalid", {63'd0, arvalid_o}, 64'd0);
        checkEq("t6_rst_err", {63'd0, err_o}, 64'd0);
        checkEq("t6_rst_addr", {32'd0, araddr_o}, 64'd0);
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        arready_i = 1'b1;
        auto_done = 1'b1;
        id_v[0] = 16'h00A0; addr_v[0] = 32'h5000;
        id_v[5] = 16'h00A5; addr_v[5] = 32'h5500;
        applyStimulus("t6_first_grant", 7'b0100001, 0);

        // Table-driven arbitration patterns.
        for (int v = 0; v < tbl.size(); v++) begin
            vec_t t;
            t = tbl[v];
            setPayload(v);
            for (int p = 0; p < N; p++) qos_v[p] = t.qos[p*4 +: 4];
            applyStimulus($sformatf("vec%0d_grant", v), t.valid, t.exp);
        end

        checkEq("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
